// File: rtl/stack_seq.sv
// Multi-register push/pop sequencer: moves a register list (plus optional LR/PC) to or from a full-descending stack.
// Latency: N+1 cycles from the start edge to done with memory always ready; each memory wait cycle adds one.
// Backpressure: each memory request is held stable until dmem_ready; start is ignored while busy.
module stack_seq #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            pop,
  input  logic [NREG-1:0] reg_list,
  input  logic            lr_en,
  input  logic [AW-1:0]   sp_in,
  input  logic [AW-1:0]   lr_in,
  input  logic [DW-1:0]   rf_rdata,
  input  logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_ready,
  output logic            busy,
  output logic            done,
  output logic            dmem_req,
  output logic            dmem_wr,
  output logic [AW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  output logic [RAW-1:0]  rf_raddr,
  output logic [RAW-1:0]  rf_waddr,
  output logic            rf_wen,
  output logic [DW-1:0]   rf_wdata,
  output logic            pc_wen,
  output logic [AW-1:0]   pc_data,
  output logic [AW-1:0]   sp_out,
  output logic            sp_wen
);

  // Transfer count ranges over 0..NREG+1.
  localparam int CW = $clog2(NREG + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_pop;
  logic            r_lr;
  logic [NREG-1:0] r_mask;
  logic [AW-1:0]   r_base;
  logic [AW-1:0]   r_newsp;
  logic [CW-1:0]   r_k;

  logic [CW-1:0]   w_n;
  logic [RAW-1:0]  w_cur_idx;
  logic [NREG-1:0] w_mask_clr;
  logic            w_is_lr;
  logic            w_last;
  logic [AW-1:0]   w_addr;

  // Number of transfers requested by the incoming command.
  always_comb begin
    w_n = CW'(lr_en);
    for (int i = 0; i < NREG; i++) begin
      w_n = w_n + CW'(reg_list[i]);
    end
  end

  // Lowest pending register index; registers go in ascending order.
  always_comb begin
    w_cur_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_cur_idx = RAW'(i);
      end
    end
  end

  // Register mask drains bit by bit, so an empty mask means the LR slot is current.
  assign w_mask_clr = r_mask & (r_mask - NREG'(1));
  assign w_is_lr    = (r_mask == '0);
  assign w_last     = w_is_lr || ((w_mask_clr == '0) && !r_lr);
  assign w_addr     = r_base + AW'(r_k);

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    dmem_req    = 1'b0;
    dmem_wr     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    rf_raddr    = '0;
    rf_waddr    = '0;
    rf_wen      = 1'b0;
    rf_wdata    = '0;
    pc_wen      = 1'b0;
    pc_data     = '0;
    sp_out      = '0;
    sp_wen      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_n != '0) ? S_XFER : S_FIN;
        end
      end
      S_XFER: begin
        busy      = 1'b1;
        dmem_req  = 1'b1;
        dmem_wr   = ~r_pop;
        dmem_addr = w_addr;
        if (!r_pop) begin
          if (w_is_lr) begin
            dmem_wdata = DW'(lr_in);
          end else begin
            rf_raddr   = w_cur_idx;
            dmem_wdata = rf_rdata;
          end
        end else if (dmem_ready) begin
          if (w_is_lr) begin
            pc_wen  = 1'b1;
            pc_data = dmem_rdata[AW-1:0];
          end else begin
            rf_wen   = 1'b1;
            rf_waddr = w_cur_idx;
            rf_wdata = dmem_rdata;
          end
        end
        if (dmem_ready && w_last) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        sp_wen      = 1'b1;
        sp_out      = r_newsp;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command capture at start and per-transfer bookkeeping on each completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pop   <= 1'b0;
      r_lr    <= 1'b0;
      r_mask  <= '0;
      r_base  <= '0;
      r_newsp <= '0;
      r_k     <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_pop   <= pop;
        r_lr    <= lr_en;
        r_mask  <= reg_list;
        r_k     <= '0;
        // Push fills downward from sp-N; pop reads upward from sp.
        r_base  <= pop ? sp_in : (sp_in - AW'(w_n));
        r_newsp <= pop ? (sp_in + AW'(w_n)) : (sp_in - AW'(w_n));
      end else if (r_state == S_XFER && dmem_ready) begin
        r_k <= r_k + CW'(1);
        if (w_is_lr) begin
          r_lr <= 1'b0;
        end else begin
          r_mask <= w_mask_clr;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int NREG = 8;
  localparam int RAW  = 3;

  logic            clk;
  logic            resetn;
  logic            start;
  logic            pop;
  logic [NREG-1:0] reg_list;
  logic            lr_en;
  logic [AW-1:0]   sp_in;
  logic [AW-1:0]   lr_in;
  logic [DW-1:0]   rf_rdata;
  logic [DW-1:0]   dmem_rdata;
  logic            dmem_ready;
  logic            busy;
  logic            done;
  logic            dmem_req;
  logic            dmem_wr;
  logic [AW-1:0]   dmem_addr;
  logic [DW-1:0]   dmem_wdata;
  logic [RAW-1:0]  rf_raddr;
  logic [RAW-1:0]  rf_waddr;
  logic            rf_wen;
  logic [DW-1:0]   rf_wdata;
  logic            pc_wen;
  logic [AW-1:0]   pc_data;
  logic [AW-1:0]   sp_out;
  logic            sp_wen;

  stack_seq #(.DW(DW), .AW(AW), .NREG(NREG), .RAW(RAW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pop(pop), .reg_list(reg_list),
    .lr_en(lr_en), .sp_in(sp_in), .lr_in(lr_in), .rf_rdata(rf_rdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .busy(busy), .done(done),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata), .pc_wen(pc_wen), .pc_data(pc_data),
    .sp_out(sp_out), .sp_wen(sp_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side models of register file and memory.
  logic [DW-1:0] rf  [NREG];
  logic [DW-1:0] mem [0:65535];

  // Per-run transfer log.
  logic [AW-1:0] lg_addr [16];
  logic          lg_wr   [16];
  logic [DW-1:0] lg_dat  [16];
  logic [3:0]    lg_dst  [16];
  int            ntr;
  int            ncomp;
  int            lat;
  int            addr_moved;
  logic [AW-1:0] got_sp;
  logic          got_spwen;
  logic          seen_done;

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {busy, done, dmem_req, dmem_wr, rf_wen, pc_wen, sp_wen}, 64'h0);
    chk({tag, "_dat"}, {sp_out, dmem_addr, pc_data, rf_waddr, rf_raddr}, 64'h0);
  endtask

  task automatic run_seq(input logic p, input logic [NREG-1:0] m, input logic l,
                         input logic [AW-1:0] sp, input int waits,
                         input int abort_at, input int inj_cyc);
    int            wc;
    int            cyc;
    bit            fin;
    logic [AW-1:0] wait_addr;
    ntr = 0; ncomp = 0; lat = -1; addr_moved = 0;
    got_sp = '0; got_spwen = 1'b0; seen_done = 1'b0;
    wc = 0; cyc = 0; fin = 1'b0; wait_addr = '0;
    @(negedge clk);
    start = 1'b1; pop = p; reg_list = m; lr_en = l; sp_in = sp; dmem_ready = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inj_cyc) begin
        start = 1'b1; pop = ~p; reg_list = 8'hF0; lr_en = 1'b1; sp_in = 16'h0999;
      end
      if (abort_at >= 0 && ncomp == abort_at) begin
        resetn = 1'b0;
        #1;
        chk_idle("abort_outs");
        @(negedge clk);
        resetn = 1'b1;
        fin = 1'b1;
      end else begin
        rf_rdata   = rf[rf_raddr];
        dmem_rdata = mem[dmem_addr];
        dmem_ready = 1'b0;
        if (dmem_req) begin
          if (wc < waits) begin
            wc++;
            wait_addr = dmem_addr;
          end else begin
            dmem_ready = 1'b1;
            if (wc > 0 && dmem_addr !== wait_addr) addr_moved++;
            wc = 0;
          end
        end
        #1;
        if (done) seen_done = 1'b1;
        if (dmem_req && dmem_ready) begin
          if (ntr < 16) begin
            lg_addr[ntr] = dmem_addr;
            lg_wr[ntr]   = dmem_wr;
            lg_dat[ntr]  = dmem_wr ? dmem_wdata : (rf_wen ? rf_wdata : {16'h0, pc_data});
            lg_dst[ntr]  = rf_wen ? {1'b0, rf_waddr} : (pc_wen ? 4'd8 : 4'd15);
            ntr++;
          end
          ncomp++;
          if (dmem_wr) mem[dmem_addr] = dmem_wdata;
          if (rf_wen)  rf[rf_waddr]   = rf_wdata;
        end
        if (done) begin
          lat = cyc; got_sp = sp_out; got_spwen = sp_wen; fin = 1'b1;
        end
        if (!fin && cyc >= 60) begin
          chk("timeout", 1, 0);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    chk_idle("post_idle");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    resetn = 1'b0; start = 1'b0; pop = 1'b0; reg_list = '0; lr_en = 1'b0;
    sp_in = '0; lr_in = 16'h1234; rf_rdata = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < NREG; i++) rf[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 4; i++) mem[16'h0200 + i] = 32'hC0DE_0000 + i;
    @(negedge clk); @(negedge clk);
    #1;
    chk_idle("reset");
    resetn = 1'b1;

    // Push R0,R2,LR from sp 0x0100.
    run_seq(1'b0, 8'h05, 1'b1, 16'h0100, 0, -1, -1);
    chk("push1_ntr",  ntr, 3);
    chk("push1_a0",   {lg_wr[0], lg_addr[0], lg_dat[0]}, {1'b1, 16'h00FD, 32'hA000_0000});
    chk("push1_a1",   {lg_wr[1], lg_addr[1], lg_dat[1]}, {1'b1, 16'h00FE, 32'hA000_0002});
    chk("push1_a2",   {lg_wr[2], lg_addr[2], lg_dat[2]}, {1'b1, 16'h00FF, 32'h0000_1234});
    chk("push1_sp",   {got_spwen, got_sp}, {1'b1, 16'h00FD});
    chk("push1_lat",  lat, 4);

    // Pop R1,R7,PC from sp 0x00FD with one wait cycle per access.
    run_seq(1'b1, 8'h82, 1'b1, 16'h00FD, 1, -1, -1);
    chk("pop1_ntr",   ntr, 3);
    chk("pop1_a0",    {lg_wr[0], lg_addr[0], lg_dst[0], lg_dat[0]}, {1'b0, 16'h00FD, 4'd1, 32'hA000_0000});
    chk("pop1_a1",    {lg_wr[1], lg_addr[1], lg_dst[1], lg_dat[1]}, {1'b0, 16'h00FE, 4'd7, 32'hA000_0002});
    chk("pop1_pc",    {lg_wr[2], lg_addr[2], lg_dst[2], lg_dat[2]}, {1'b0, 16'h00FF, 4'd8, 32'h0000_1234});
    chk("pop1_sp",    {got_spwen, got_sp}, {1'b1, 16'h0100});
    chk("pop1_lat",   lat, 7);
    chk("pop1_stable", addr_moved, 0);

    // Empty list: straight to FIN.
    run_seq(1'b0, 8'h00, 1'b0, 16'h0040, 0, -1, -1);
    chk("empty_ntr",  ntr, 0);
    chk("empty_sp",   {seen_done, got_spwen, got_sp}, {1'b1, 1'b1, 16'h0040});
    chk("empty_lat",  lat, 1);

    // Push wrapping below address zero.
    run_seq(1'b0, 8'h07, 1'b0, 16'h0001, 0, -1, -1);
    chk("wrap_ntr",   ntr, 3);
    chk("wrap_addrs", {lg_addr[0], lg_addr[1], lg_addr[2]}, {16'hFFFE, 16'hFFFF, 16'h0000});
    chk("wrap_dat",   {lg_dat[1], lg_dat[2]}, {32'hA000_0000, 32'hA000_0002});
    chk("wrap_sp",    {got_spwen, got_sp}, {1'b1, 16'hFFFE});
    chk("wrap_lat",   lat, 4);

    // Pop of four registers aborted by reset after two completions.
    run_seq(1'b1, 8'h0F, 1'b0, 16'h0200, 0, 2, -1);
    chk("abort_ncomp", ncomp, 2);
    chk("abort_done",  seen_done, 0);
    chk("abort_a1",    {lg_addr[1], lg_dst[1], lg_dat[1]}, {16'h0201, 4'd1, 32'hC0DE_0001});

    // Same pop after the abort runs to completion.
    run_seq(1'b1, 8'h0F, 1'b0, 16'h0200, 0, -1, -1);
    chk("rerun_ntr",  ntr, 4);
    chk("rerun_a3",   {lg_addr[3], lg_dst[3], lg_dat[3]}, {16'h0203, 4'd3, 32'hC0DE_0003});
    chk("rerun_sp",   {got_spwen, got_sp}, {1'b1, 16'h0204});
    chk("rerun_lat",  lat, 5);

    // Push with a conflicting start pulsed mid-transfer.
    run_seq(1'b0, 8'h03, 1'b0, 16'h0300, 0, -1, 1);
    chk("ign_ntr",    ntr, 2);
    chk("ign_a0",     {lg_wr[0], lg_addr[0], lg_dat[0]}, {1'b1, 16'h02FE, 32'hC0DE_0000});
    chk("ign_a1",     {lg_wr[1], lg_addr[1], lg_dat[1]}, {1'b1, 16'h02FF, 32'hC0DE_0001});
    chk("ign_sp",     {got_spwen, got_sp}, {1'b1, 16'h02FE});
    chk("ign_lat",    lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW  32  data word width
- AW  16  word address width
- NREG  8  architectural registers covered by the register list
- RAW  clog2(NREG)  register address width
REQ-002 Ports, one per line: name  direction  width  meaning (clock and reset first).
- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a multi-register transfer
- pop  in  1  sampled with start: 1 = pop (memory to registers), 0 = push (registers to memory)
- reg_list  in  NREG  register mask, sampled with start
- lr_en  in  1  sampled with start: include link register (push LR / pop into PC)
- sp_in  in  AW  current stack pointer, sampled with start
- lr_in  in  AW  link register value, used during push
- rf_rdata  in  DW  register file read data (combinational from rf_raddr)
- dmem_rdata  in  DW  memory read data, valid when dmem_ready=1
- dmem_ready  in  1  memory accepts/completes the current request this cycle
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- dmem_req  out  1  memory request valid
- dmem_wr  out  1  request is a write
- dmem_addr  out  AW  word address
- dmem_wdata  out  DW  write data
- rf_raddr  out  RAW  register read address
- rf_waddr  out  RAW  register write address
- rf_wen  out  1  register write strobe
- rf_wdata  out  DW  register write data
- pc_wen  out  1  write pc_data to PC
- pc_data  out  AW  PC value (low AW bits of popped word)
- sp_out  out  AW  updated stack pointer
- sp_wen  out  1  stack pointer write strobe

Function
REQ-003 States: IDLE, XFER, FIN; busy=1 in XFER and FIN.
REQ-004 IDLE: start=1 latches pop, reg_list, lr_en, sp_in; N = popcount(reg_list)+lr_en (0..NREG+1); N>0 -> XFER, N=0 -> FIN.
REQ-005 start while busy is ignored, with no effect on the sequence in progress.
REQ-006 Transfer order: ascending register index, LR last; the k-th transfer (k=0..N-1) uses one address.
REQ-007 Push addresses: sp-N+k; new SP = sp-N (full-descending stack). Pop addresses: sp+k; new SP = sp+N.
REQ-008 All address arithmetic is modulo 2^AW (wrap-around permitted, no error).
REQ-009 XFER: dmem_req=1 with dmem_addr and dmem_wr=~pop held stable until dmem_ready=1; the transfer completes in the cycle dmem_ready=1.
REQ-010 Push register transfer: rf_raddr = current register index; dmem_wdata = rf_rdata. Push LR transfer: dmem_wdata = zero-extended lr_in.
REQ-011 Pop register transfer: rf_wen=1, rf_waddr=index, rf_wdata=dmem_rdata, asserted only in the completing cycle. Pop LR transfer: pc_wen=1, pc_data=dmem_rdata[AW-1:0], asserted only in the completing cycle.
REQ-012 Completion of the last transfer -> FIN; otherwise the sequence advances to the next set bit in the same completion cycle.
REQ-013 FIN (one cycle): sp_wen=1, sp_out=new SP, done=1; next state IDLE.
REQ-014 Latency with dmem_ready tied high: N+1 cycles from the start edge to done; each wait cycle adds one.
REQ-015 In IDLE: dmem_req, dmem_wr, rf_wen, pc_wen, sp_wen, and done are 0.

Reset
REQ-016 resetn=0 forces IDLE immediately, regardless of clk.
REQ-017 Reset values: all outputs 0; latched mask, SP, and counters cleared.
REQ-018 Reset mid-sequence aborts the sequence: no sp_wen, no done; register and memory writes already completed are not undone.

Verification
REQ-019 Push reg_list=0x05, lr_en=1, sp_in=0x0100, lr_in=0x1234, ready=1 -> writes at 0x00FD (R0), 0x00FE (R2), 0x00FF (0x00001234); FIN: sp_out=0x00FD, sp_wen=1; done 4 cycles after start.
REQ-020 Pop reg_list=0x82, lr_en=1, sp_in=0x00FD, one wait cycle per access -> R1 from 0x00FD, R7 from 0x00FE, pc_wen from 0x00FF; sp_out=0x0100; done 7 cycles after start; address stable during waits.
REQ-021 Push reg_list=0x00, lr_en=0 -> no dmem_req; FIN on the next cycle with sp_out=sp_in and done=1.
REQ-022 Push reg_list=0x07, sp_in=0x0001 -> addresses 0xFFFE, 0xFFFF, 0x0000; sp_out=0xFFFE.
REQ-023 Pop of 4 registers, resetn low after the second completion -> IDLE, outputs 0, no sp_wen or done; a following start runs normally.
REQ-024 start pulsed during XFER with a different mask -> ignored; original sequence completes unchanged.
